keccak_xif_issue_buffer: RTL

// - Speculative issue buffer between the core's XIF issue/commit interfaces and the Keccak XIF controller.
// - Holds accepted Keccak instructions until the core commits or kills them; forwards only committed ones, in issue order.
// - Silently drops killed entries, so the controller and Keccak datapath never start speculative work.

---
 rtl/keccak_xif_issue_buffer_pkg.sv | 30 +++
 rtl/keccak_xif_issue_buffer_if.sv | 50 +++++
 rtl/keccak_xif_issue_buffer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/keccak_xif_issue_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keccak_xif_issue_buffer_pkg
// Purpose  : Shared types for the Keccak XIF speculative issue buffer.
// Revision : 1.0 - initial release
// ============================================================================
package keccak_xif_issue_buffer_pkg;

  localparam int C_ID_W    = 4;
  localparam int C_XLEN    = 32;
  localparam int C_INSTR_W = 32;

  // Lifecycle of one buffer slot.
  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    PENDING   = 2'd1,
    COMMITTED = 2'd2,
    KILLED    = 2'd3
  } entry_state_t;

  typedef struct packed {
    logic [C_ID_W-1:0]    id;
    logic [C_INSTR_W-1:0] instr;
    logic [C_XLEN-1:0]    rs0;
    logic [C_XLEN-1:0]    rs1;
    entry_state_t         state;
  } issue_entry_t;

endpackage
`default_nettype wire

// File: rtl/keccak_xif_issue_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : keccak_xif_issue_buffer_if
// Purpose  : Issue, commit and output handshake bundle of the issue buffer.
//            master = core/controller side, slave = buffer side.
// Revision : 1.0 - initial release
// ============================================================================
interface keccak_xif_issue_buffer_if
  import keccak_xif_issue_buffer_pkg::*;
#(
  parameter int ID_W = 4,
  parameter int XLEN = 32
);

  logic                 issue_valid_i;
  logic                 issue_ready_o;
  logic [ID_W-1:0]      issue_id_i;
  logic [C_INSTR_W-1:0] issue_instr_i;
  logic [XLEN-1:0]      issue_rs0_i;
  logic [XLEN-1:0]      issue_rs1_i;

  logic                 commit_valid_i;
  logic [ID_W-1:0]      commit_id_i;
  logic                 commit_kill_i;

  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [ID_W-1:0]      out_id_o;
  logic [C_INSTR_W-1:0] out_instr_o;
  logic [XLEN-1:0]      out_rs0_o;
  logic [XLEN-1:0]      out_rs1_o;

  modport master (
    output issue_valid_i, issue_id_i, issue_instr_i, issue_rs0_i, issue_rs1_i,
    input  issue_ready_o,
    output commit_valid_i, commit_id_i, commit_kill_i,
    input  out_valid_o, out_id_o, out_instr_o, out_rs0_o, out_rs1_o,
    output out_ready_i
  );

  modport slave (
    input  issue_valid_i, issue_id_i, issue_instr_i, issue_rs0_i, issue_rs1_i,
    output issue_ready_o,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    output out_valid_o, out_id_o, out_instr_o, out_rs0_o, out_rs1_o,
    input  out_ready_i
  );

endinterface
`default_nettype wire

// File: rtl/keccak_xif_issue_buffer.sv
`default_nettype none
// ============================================================================
// Module   : keccak_xif_issue_buffer
// Purpose  : Holds issued Keccak instructions until commit/kill; forwards
//            committed ones in issue order, silently drops killed ones.
// Revision : 1.0 - initial release
// ============================================================================
module keccak_xif_issue_buffer
  import keccak_xif_issue_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4,
  parameter int XLEN  = 32
) (
  input  wire                         clk_i,
  input  wire                         rst_i,
  keccak_xif_issue_buffer_if.slave    bus,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

  entry_state_t         r_state [DEPTH];
  logic [ID_W-1:0]      r_id    [DEPTH];
  logic [C_INSTR_W-1:0] r_instr [DEPTH];
  logic [XLEN-1:0]      r_rs0   [DEPTH];
  logic [XLEN-1:0]      r_rs1   [DEPTH];

  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic                 r_err;

  logic [DEPTH-1:0]     w_dup_hit;
  logic [DEPTH-1:0]     w_cmt_hit;
  logic                 w_full;
  logic                 w_ready;
  logic                 w_push;
  logic                 w_same;
  logic                 w_cmt_old;
  logic                 w_err_evt;
  logic                 w_pop;
  entry_state_t         w_head_state;
  entry_state_t         w_cmt_state;
  entry_state_t         w_new_state;

  // Id CAM: one comparator pair per slot, for duplicate-issue stall and commit lookup.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cam
      assign w_dup_hit[gi] = ((r_state[gi] == PENDING) || (r_state[gi] == COMMITTED))
                             && (r_id[gi] == bus.issue_id_i);
      assign w_cmt_hit[gi] = (r_state[gi] == PENDING) && (r_id[gi] == bus.commit_id_i);
    end
  endgenerate

  // Handshake decode; ready uses registered state only, so a same-cycle pop never frees a slot.
  always_comb begin
    w_full       = (r_count == C_FULL);
    w_ready      = !w_full && !(|w_dup_hit);
    w_push       = bus.issue_valid_i && w_ready;
    // A duplicate id can never be accepted, so a commit matching the accepted id
    // cannot also match an older pending slot.
    w_same       = bus.commit_valid_i && w_push && (bus.commit_id_i == bus.issue_id_i);
    w_cmt_old    = bus.commit_valid_i && !w_same && (|w_cmt_hit);
    w_err_evt    = bus.commit_valid_i && !w_same && !(|w_cmt_hit);
    w_cmt_state  = bus.commit_kill_i ? KILLED : COMMITTED;
    w_new_state  = w_same ? w_cmt_state : PENDING;
    w_head_state = r_state[r_head];
    w_pop        = ((w_head_state == COMMITTED) && bus.out_ready_i) || (w_head_state == KILLED);
  end

  // Slot states, pointers, occupancy and sticky error; cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= EMPTY;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_cmt_old && w_cmt_hit[i]) begin
          r_state[i] <= w_cmt_state;
        end
      end
      if (w_pop) begin
        r_state[r_head] <= EMPTY;
        r_head          <= r_head + C_PTR_ONE;
      end
      if (w_push) begin
        r_state[r_tail] <= w_new_state;
        r_tail          <= r_tail + C_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  // Payload storage; only meaningful while the slot state is not EMPTY.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_id[r_tail]    <= bus.issue_id_i;
      r_instr[r_tail] <= bus.issue_instr_i;
      r_rs0[r_tail]   <= bus.issue_rs0_i;
      r_rs1[r_tail]   <= bus.issue_rs1_i;
    end
  end

  assign bus.issue_ready_o = w_ready;
  assign bus.out_valid_o   = (w_head_state == COMMITTED);
  assign bus.out_id_o      = r_id[r_head];
  assign bus.out_instr_o   = r_instr[r_head];
  assign bus.out_rs0_o     = r_rs0[r_head];
  assign bus.out_rs1_o     = r_rs1[r_head];
  assign count_o           = r_count;
  assign err_o             = r_err;

endmodule
`default_nettype wire
